// File: rtl/spi_temp_read_ctrl.sv
// spi_temp_read_ctrl: mode-0 read-only SPI master that clocks one
// FRAME_BITS frame from a temperature sensor, MSB first.
//
// Ports:
//   clk, rst   - system clock; asynchronous active-high reset
//   start      - read request, sampled only in IDLE
//   auto_en    - enables periodic reads (AUTO_SAMPLE_EN builds only)
//   miso       - sensor serial data
//   cs_n, sclk - sensor chip select (active low) and serial clock
//   busy       - high in every state except IDLE
//   new_data   - 1-cycle strobe: frame_out has just been updated
//   frame_out  - last complete frame, MSB = first bit received
//
// Build option: define AUTO_SAMPLE_EN to add the periodic read timer.

module spi_temp_read_ctrl #(
  parameter int CLK_DIV       = 4,
  parameter int FRAME_BITS    = 24,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  auto_en,
  input  logic                  miso,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  busy,
  output logic                  new_data,
  output logic [FRAME_BITS-1:0] frame_out
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE,
    GAP
  } state_t;

  state_t                state;
  state_t                state_d;
  logic [DW-1:0]         div_cnt;
  logic                  tick;
  logic                  go;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] shreg;

  assign tick = (div_cnt == DW'(CLK_DIV - 1));

`ifdef AUTO_SAMPLE_EN
  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  logic [PW-1:0] per_cnt;
  logic          per_tc;
  logic          pending;

  assign per_tc = auto_en && (per_cnt == PW'(SAMPLE_PERIOD - 1));
  assign go     = start | pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
    end else if (!auto_en || per_tc) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // Leaving IDLE always consumes the request, so a trigger that
  // coincides with start still yields a single frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (state == IDLE && go) begin
      pending <= 1'b0;
    end else if (per_tc) begin
      pending <= 1'b1;
    end
  end
`else
  logic unused_auto;

  assign unused_auto = auto_en;
  assign go          = start;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    cs_n    = 1'b1;
    busy    = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (go) state_d = SETUP;
      end
      SETUP: begin
        cs_n = 1'b0;
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        cs_n = 1'b0;
        // Leave on the falling toggle after the last rising edge.
        if (tick && sclk && bit_cnt == BW'(FRAME_BITS))
          state_d = HOLD;
      end
      HOLD: begin
        cs_n = 1'b0;
        if (tick) state_d = DONE;
      end
      DONE: begin
        state_d = GAP;
      end
      GAP: begin
        if (tick) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      sclk      <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_out <= '0;
      new_data  <= 1'b0;
    end else begin
      new_data <= 1'b0;

      if (state == IDLE || state_d != state || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (state == SHIFT) begin
        if (tick) begin
          sclk <= ~sclk;
          if (!sclk) begin
            shreg   <= {shreg[FRAME_BITS-2:0], miso};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end else begin
        sclk    <= 1'b0;
        bit_cnt <= '0;
      end

      if (state == DONE) begin
        frame_out <= shreg;
        new_data  <= 1'b1;
      end
    end
  end

endmodule
